// File: rtl/enemy_patrol_mover.sv
// enemy_patrol_mover: walks NUM_ENEMIES sprites left/right over the tile map,
// turns them at blocks and screen edges, and resolves stomp/contact with Mario.
// Optional feature: define ENEMY_LEDGE_TURN_EN to make walkers also turn
// before stepping off a ledge (no BLK/GND tile under the leading edge).
module enemy_patrol_mover #(
    parameter int         NUM_ENEMIES     = 4,
    parameter int         STEP            = 1,
    parameter int         START_RIGHT     = 1,
    parameter int         CHARACTER_WIDTH = 42,
    parameter int         SCREEN_WIDTH    = 640,
    parameter int         BLOCK_WIDTH     = 40,
    parameter logic [7:0] BLK             = 8'd2,
    parameter logic [7:0] GND             = 8'd3,
    parameter int         OFFSCREEN_X     = 1000,
    parameter int         KC_W            = 8
) (
    input  logic                    movement_clock,
    input  logic                    reset,
    input  logic [11:0][16:0][7:0]  background,
    input  int                      mario_x,
    input  int                      mario_y,
    input  int                      enemy_x_initial [NUM_ENEMIES],
    input  int                      enemy_y         [NUM_ENEMIES],
    output int                      enemy_x         [NUM_ENEMIES],
    output logic [NUM_ENEMIES-1:0]  enemy_alive,
    output logic                    lose,
    output logic                    stomp_pulse,
    output logic [KC_W-1:0]         kill_count
);

    typedef enum logic [2:0] {CH_INIT, CH_LOAD, CH_LEFT, CH_RIGHT, CH_DEAD} ch_state_t;
    typedef enum logic {G_RUN, G_LOST} g_state_t;

    localparam logic [KC_W+4:0] KILL_MAX = {5'd0, {KC_W{1'b1}}};

    ch_state_t              ch_state      [NUM_ENEMIES];
    ch_state_t              ch_state_next [NUM_ENEMIES];
    g_state_t               g_state, g_state_next;
    int                     x_next        [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0] alive_next;
    logic                   lose_next, pulse_next;
    logic [KC_W-1:0]        kill_next;
    logic [NUM_ENEMIES-1:0] is_contact, is_stomp, is_blocked;

    function automatic logic [3:0] clamp_row(input int v);
        if (v < 0)       return 4'd0;
        else if (v > 11) return 4'd11;
        else             return v[3:0];
    endfunction

    function automatic logic [4:0] clamp_col(input int v);
        if (v < 0)       return 5'd0;
        else if (v > 16) return 5'd16;
        else             return v[4:0];
    endfunction

    // Per-channel hazard detection: Mario overlap (stomp/contact) and obstacle ahead.
    always_comb begin : detect
        logic [3:0] row_t, row_b;
        logic [4:0] col;
        logic       edge_hit, overlap, walking;
`ifdef ENEMY_LEDGE_TURN_EN
        logic [7:0] below;
        below = '0;
`endif
        row_t      = '0;
        row_b      = '0;
        col        = '0;
        edge_hit   = 1'b0;
        overlap    = 1'b0;
        walking    = 1'b0;
        is_contact = '0;
        is_stomp   = '0;
        is_blocked = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            row_t = clamp_row(enemy_y[i] / BLOCK_WIDTH);
            row_b = clamp_row((enemy_y[i] + CHARACTER_WIDTH - 1) / BLOCK_WIDTH);
            if (ch_state[i] == CH_LEFT) begin
                col      = clamp_col((enemy_x[i] - 1) / BLOCK_WIDTH);
                edge_hit = (enemy_x[i] - STEP) < 0;
            end else begin
                col      = clamp_col((enemy_x[i] + CHARACTER_WIDTH + 1) / BLOCK_WIDTH);
                edge_hit = (enemy_x[i] + CHARACTER_WIDTH + STEP) > SCREEN_WIDTH;
            end
            is_blocked[i] = edge_hit || (background[row_t][col] == BLK)
                                     || (background[row_b][col] == BLK);
`ifdef ENEMY_LEDGE_TURN_EN
            // A missing floor under the leading edge counts as an obstacle;
            // the row below the map is treated as solid.
            if (row_b != 4'd11) begin
                below = background[row_b + 4'd1][col];
                if (below != BLK && below != GND)
                    is_blocked[i] = 1'b1;
            end
`endif
            walking = (ch_state[i] == CH_LEFT) || (ch_state[i] == CH_RIGHT);
            overlap = (mario_x + CHARACTER_WIDTH >= enemy_x[i]) &&
                      (mario_x <= enemy_x[i] + CHARACTER_WIDTH);
            is_stomp[i]   = walking && overlap && (mario_y + CHARACTER_WIDTH == enemy_y[i]);
            is_contact[i] = walking && overlap && (mario_y + CHARACTER_WIDTH > enemy_y[i])
                                               && (mario_y < enemy_y[i] + CHARACTER_WIDTH);
        end
    end

    // Next-state logic: contact anywhere freezes the game, otherwise each channel
    // loads, dies, turns or steps, and stomps on one edge are summed into the counter.
    always_comb begin : next_state
        logic [4:0]      kills;
        logic [KC_W+4:0] kill_sum;
        g_state_next = g_state;
        lose_next    = lose;
        pulse_next   = 1'b0;
        kill_next    = kill_count;
        alive_next   = enemy_alive;
        kills        = '0;
        kill_sum     = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            ch_state_next[i] = ch_state[i];
            x_next[i]        = enemy_x[i];
        end
        if (g_state == G_RUN) begin
            if (|is_contact) begin
                g_state_next = G_LOST;
                lose_next    = 1'b1;
            end else begin
                for (int i = 0; i < NUM_ENEMIES; i++) begin
                    case (ch_state[i])
                        CH_INIT, CH_LOAD: begin
                            x_next[i]        = enemy_x_initial[i];
                            alive_next[i]    = 1'b1;
                            ch_state_next[i] = (START_RIGHT != 0) ? CH_RIGHT : CH_LEFT;
                        end
                        CH_LEFT, CH_RIGHT: begin
                            if (is_stomp[i]) begin
                                ch_state_next[i] = CH_DEAD;
                                x_next[i]        = OFFSCREEN_X;
                                alive_next[i]    = 1'b0;
                                kills            = kills + 5'd1;
                            end else if (is_blocked[i]) begin
                                ch_state_next[i] = (ch_state[i] == CH_LEFT) ? CH_RIGHT : CH_LEFT;
                            end else if (ch_state[i] == CH_LEFT) begin
                                x_next[i] = enemy_x[i] - STEP;
                            end else begin
                                x_next[i] = enemy_x[i] + STEP;
                            end
                        end
                        CH_DEAD: ;
                        default: ch_state_next[i] = CH_INIT;
                    endcase
                end
                if (kills != 5'd0) begin
                    pulse_next = 1'b1;
                    kill_sum   = {5'd0, kill_count} + {{KC_W{1'b0}}, kills};
                    kill_next  = (kill_sum > KILL_MAX) ? {KC_W{1'b1}} : kill_sum[KC_W-1:0];
                end
            end
        end
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge movement_clock or negedge reset) begin
        if (!reset) begin
            g_state     <= G_RUN;
            lose        <= 1'b0;
            stomp_pulse <= 1'b0;
            kill_count  <= '0;
            enemy_alive <= '0;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                ch_state[i] <= CH_INIT;
                enemy_x[i]  <= 0;
            end
        end else begin
            g_state     <= g_state_next;
            lose        <= lose_next;
            stomp_pulse <= pulse_next;
            kill_count  <= kill_next;
            enemy_alive <= alive_next;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                ch_state[i] <= ch_state_next[i];
                enemy_x[i]  <= x_next[i];
            end
        end
    end

endmodule
